// File: rtl/addsub_flag_pipe_if.sv
// Operand/result bus for addsub_flag_pipe: operand handshake, result handshake, accumulator view.
// The master side drives operands and out_ready; the slave side is the pipeline stage.
interface addsub_flag_pipe_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_w;
   logic             in_acc;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic [3:0]       out_flags;
   logic [WIDTH-1:0] acc_q;

   modport master (
      output in_valid, in_a, in_b, in_w, in_acc, acc_clr, out_ready,
      input  in_ready, out_valid, out_sum, out_flags, acc_q
   );

   modport slave (
      input  in_valid, in_a, in_b, in_w, in_acc, acc_clr, out_ready,
      output in_ready, out_valid, out_sum, out_flags, acc_q
   );
endinterface

// File: rtl/addsub_flag_pipe.sv
// Add/subtract stage: CLA datapath with NZCV flags, running accumulator and a
// 2-entry skid buffer whose head entry drives the result outputs directly.
module addsub_flag_pipe #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   addsub_flag_pipe_if.slave  bus
);
   localparam int EW = WIDTH + 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   skid_state_t      r_state;
   skid_state_t      w_state_nxt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [EW-1:0]    r_ent0;
   logic [EW-1:0]    r_ent1;
   logic [WIDTH-1:0] r_acc;

   logic             w_accept;
   logic             w_pop;
   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_opb;
   logic [WIDTH:0]   w_cs;
   logic [WIDTH-1:0] w_sum;
   logic [3:0]       w_flags;
   logic [EW-1:0]    w_new;

   // Carry-lookahead adder built from 4-bit lookahead slices chained slice to slice.
   function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             cin);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH:0]   c;
      int               k;
      g    = a & b;
      p    = a ^ b;
      c    = {(WIDTH+1){1'b0}};
      c[0] = cin;
      for (int s = 0; s < WIDTH / 4; s++) begin
         k        = 4 * s;
         c[k+1]   = g[k] | (p[k] & c[k]);
         c[k+2]   = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
         c[k+3]   = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
                  | (p[k+2] & p[k+1] & p[k] & c[k]);
         c[k+4]   = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
                  | (p[k+3] & p[k+2] & p[k+1] & g[k])
                  | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
      end
      return {c[WIDTH], p ^ c[WIDTH-1:0]};
   endfunction

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_pop    = r_out_valid & bus.out_ready;

   always_comb begin
      w_opa = bus.in_a;
      if (bus.in_acc) begin
         w_opa = r_acc;
      end else begin
         w_opa = bus.in_a;
      end
      w_opb      = bus.in_b ^ {WIDTH{bus.in_w}};
      w_cs       = cla_add(w_opa, w_opb, bus.in_w);
      w_sum      = w_cs[WIDTH-1:0];
      w_flags[3] = w_sum[WIDTH-1];
      w_flags[2] = (w_sum == {WIDTH{1'b0}});
      w_flags[1] = w_cs[WIDTH];
      w_flags[0] = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != w_opa[WIDTH-1]);
      w_new      = {w_sum, w_flags};
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: begin
            if (w_accept) w_state_nxt = ONE;
            else          w_state_nxt = EMPTY;
         end
         ONE: begin
            if (w_accept && !w_pop)      w_state_nxt = FULL;
            else if (w_pop && !w_accept) w_state_nxt = EMPTY;
            else                         w_state_nxt = ONE;
         end
         FULL: begin
            if (w_pop) w_state_nxt = ONE;
            else       w_state_nxt = FULL;
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Handshake flags are registered copies of the next occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != FULL);
         r_out_valid <= (w_state_nxt != EMPTY);
      end
   end

   // r_ent0 is always the head so outputs come straight from a register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ent0 <= {EW{1'b0}};
         r_ent1 <= {EW{1'b0}};
      end else if (w_pop) begin
         if (r_state == FULL) r_ent0 <= r_ent1;
         else if (w_accept)   r_ent0 <= w_new;
      end else if (w_accept) begin
         if (r_state == EMPTY) r_ent0 <= w_new;
         else                  r_ent1 <= w_new;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= {WIDTH{1'b0}};
      end else if (bus.acc_clr) begin
         r_acc <= {WIDTH{1'b0}};
      end else if (w_accept) begin
         r_acc <= w_sum;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_ent0[EW-1:4];
   assign bus.out_flags = r_ent0[3:0];
   assign bus.acc_q     = r_acc;
endmodule

// File: tb/tb_addsub_flag_pipe.sv
// Randomized scoreboard bench for addsub_flag_pipe with directed corner cases.
// Expected results come from signed/unsigned integer arithmetic on the accepted beats.
module tb_addsub_flag_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rnd_or = 1'b0;
   logic rnd_val = 1'b1;
   logic or_val = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [35:0] sb[$];
   logic [31:0] m_acc = 32'd0;

   addsub_flag_pipe_if #(.WIDTH(32)) bus ();

   addsub_flag_pipe #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   assign bus.out_ready = rnd_or ? rnd_val : or_val;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                              input logic w);
      longint sa, sb_v, sr;
      logic [32:0] u;
      logic [31:0] s;
      logic c, v;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      if (!w) begin
         u  = {1'b0, a} + {1'b0, b};
         s  = u[31:0];
         c  = u[32];
         sr = sa + sb_v;
      end else begin
         s  = a - b;
         c  = (a >= b);
         sr = sa - sb_v;
      end
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {s, s[31], (s == 32'd0), c, v};
   endfunction

   // Reference model: observes accepted beats and predicts results and accumulator.
   initial forever begin
      logic [31:0] opa;
      logic [35:0] r;
      @(negedge clk);
      if (!rst_n) begin
         sb.delete();
         m_acc = 32'd0;
      end else begin
         chk("acc_q", {32'd0, bus.acc_q}, {32'd0, m_acc});
         if (bus.in_valid && bus.in_ready) begin
            opa = bus.in_acc ? m_acc : bus.in_a;
            r = ref_result(opa, bus.in_b, bus.in_w);
            sb.push_back(r);
            if (!bus.acc_clr) m_acc = r[35:4];
         end
         if (bus.acc_clr) m_acc = 32'd0;
      end
   end

   // Monitor: pops on each output transfer and checks stability while stalled.
   initial begin
      logic        prev_stall;
      logic [35:0] prev_out;
      logic [35:0] e;
      prev_stall = 1'b0;
      prev_out   = 36'd0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_stall) begin
               chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
               chk("stall_data", {28'd0, bus.out_sum, bus.out_flags}, {28'd0, prev_out});
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", {28'd0, bus.out_sum, bus.out_flags}, 64'd0 - 64'd1);
               end else begin
                  e = sb.pop_front();
                  chk("result", {28'd0, bus.out_sum, bus.out_flags}, {28'd0, e});
               end
            end
         end
         prev_stall = rst_n && bus.out_valid && !bus.out_ready;
         prev_out   = {bus.out_sum, bus.out_flags};
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      rnd_val = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic w,
                        input logic acc, input logic clr);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_w     = w;
      bus.in_acc   = acc;
      bus.acc_clr  = clr;
   endtask

   task automatic wait_accept();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 60);
      if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.acc_clr  = 1'b0;
   endtask

   task automatic send_check(input logic [31:0] a, input logic [31:0] b, input logic w,
                             input logic acc, input logic [31:0] es, input logic [3:0] ef,
                             input string name);
      drive(a, b, w, acc, 1'b0);
      wait_accept();
      @(negedge clk);
      chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
      chk({name, "_sum"}, {32'd0, bus.out_sum}, {32'd0, es});
      chk({name, "_flags"}, {60'd0, bus.out_flags}, {60'd0, ef});
      @(posedge clk);
      #1;
   endtask

   task automatic clear_acc();
      bus.acc_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.acc_clr = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_a     = 32'd0;
      bus.in_b     = 32'd0;
      bus.in_w     = 1'b0;
      bus.in_acc   = 1'b0;
      bus.acc_clr  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst_acc_q", {32'd0, bus.acc_q}, 64'd0);
      chk("rst_out_sum", {32'd0, bus.out_sum}, 64'd0);
      chk("rst_out_flags", {60'd0, bus.out_flags}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      send_check(32'h5, 32'h3, 1'b0, 1'b0, 32'h8, 4'b0000, "add");
      send_check(32'h3, 32'h5, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b1000, "sub_borrow");
      send_check(32'h5, 32'h5, 1'b1, 1'b0, 32'h0, 4'b0110, "sub_zero");
      send_check(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 4'b1001, "add_ovf");
      send_check(32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0011, "sub_ovf");

      clear_acc();
      send_check(32'hDEAD_BEEF, 32'd10, 1'b0, 1'b1, 32'd10, 4'b0000, "acc1");
      send_check(32'hDEAD_BEEF, 32'd20, 1'b0, 1'b1, 32'd30, 4'b0000, "acc2");
      send_check(32'hDEAD_BEEF, 32'd5, 1'b1, 1'b1, 32'd25, 4'b0010, "acc3");
      @(negedge clk);
      chk("acc_final", {32'd0, bus.acc_q}, 64'd25);
      @(posedge clk);
      #1;

      or_val = 1'b0;
      clear_acc();
      drive(32'd0, 32'd10, 1'b0, 1'b1, 1'b0);
      wait_accept();
      drive(32'd0, 32'd20, 1'b0, 1'b1, 1'b0);
      wait_accept();
      drive(32'd0, 32'd5, 1'b1, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      end
      chk("stall_acc_q", {32'd0, bus.acc_q}, 64'd30);
      @(posedge clk);
      #1;
      or_val = 1'b1;
      wait_accept();
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("stall_acc_final", {32'd0, bus.acc_q}, 64'd25);
      chk("stall_drained", {32'd0, 32'(sb.size())}, 64'd0);
      @(posedge clk);
      #1;

      rnd_or = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] a, b;
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         case ($urandom_range(0, 4))
            0: a = 32'h7FFF_FFFF;
            1: a = 32'h8000_0000;
            2: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 4) == 0) ? a : $urandom;
         drive(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 15) == 0));
         wait_accept();
      end
      rnd_or = 1'b0;
      or_val = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.out_valid) break;
      end
      chk("random_drained", {32'd0, 32'(sb.size())}, 64'd0);
      @(posedge clk);
      #1;

      or_val = 1'b0;
      drive(32'h1234, 32'h0, 1'b0, 1'b0, 1'b0);
      wait_accept();
      drive(32'h1000, 32'h234, 1'b0, 1'b0, 1'b0);
      wait_accept();
      @(negedge clk);
      chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("full_acc_q", {32'd0, bus.acc_q}, 64'h1234);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      or_val = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("mid_rst_acc_q", {32'd0, bus.acc_q}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      send_check(32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 4'b0000, "post_rst");
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
